line_scheduler: RTL and testbench

- Sequences PixelGenerator across all scan rows and hands completed lines to the HUB-75 scan-out stage.
- Line RAM is double-buffered, with the bank selected by y[0]. The scheduler fills one bank while scan-out displays the other.
- Owns the row pointers and the frame counter, and keeps a saturating underrun count for bring-up.

---
 rtl/hub75_pkg.sv | 22 ++
 rtl/CascadeCounter.sv | 28 ++
 rtl/row_pointer.sv | 29 ++
 rtl/line_scheduler.sv | 124 ++++++++++++
 tb/tb_line_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// Shared HUB-75 definitions: panel geometry defaults and line-scheduler state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hub75_pkg;

   localparam int ROWS        = 32;
   localparam int Y_WIDTH     = 5;
   localparam int FRAME_WIDTH = 10;

   typedef enum logic [1:0] {
      kIdle,
      kArm,
      kBusy
   } fill_state_t;

   typedef enum logic [1:0] {
      kDispIdle,
      kDispWait,
      kDispBusy
   } disp_state_t;

endpackage

// File: rtl/CascadeCounter.sv
// Free-running binary counter stage that advances on carry_in and can be chained.
// Latency: count updates on the edge after i_carry_in; o_carry_out is combinational.
// Backpressure: none.
module CascadeCounter #(
   parameter int WIDTH = 10
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_carry_in,
   output logic [WIDTH-1:0] o_count,
   output logic             o_carry_out
);

   logic [WIDTH-1:0] r_count;

   assign o_count     = r_count;
   assign o_carry_out = i_carry_in && (&r_count);

   // Count carries in; rolls over naturally at 2^WIDTH.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_carry_in) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/row_pointer.sv
// Modulo-ROWS row index with an increment strobe and a wrap pulse.
// Latency: index updates on the edge after i_inc; o_wrap is combinational with i_inc.
// Backpressure: none; every i_inc is taken.
module row_pointer #(
   parameter int ROWS    = hub75_pkg::ROWS,
   parameter int Y_WIDTH = hub75_pkg::Y_WIDTH
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_inc,
   output logic [Y_WIDTH-1:0] o_y,
   output logic               o_wrap
);

   logic [Y_WIDTH-1:0] r_y;

   assign o_wrap = i_inc && (r_y == Y_WIDTH'(ROWS - 1));
   assign o_y    = r_y;

   // Advance the row, folding back to 0 after the last row.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_y <= '0;
      end else if (i_inc) begin
         r_y <= o_wrap ? '0 : r_y + 1'b1;
      end
   end

endmodule

// File: rtl/line_scheduler.sv
// Sequences the pixel generator over all rows into a two-bank line RAM and hands full banks to scan-out.
// Latency: gen_start 1 cycle after a fill is allowed; disp_start 1 cycle after a bank becomes ready.
// Backpressure: fill stalls while the target bank is still full; display waits in kDispWait for its bank.
module line_scheduler #(
   parameter int ROWS           = hub75_pkg::ROWS,
   parameter int Y_WIDTH        = hub75_pkg::Y_WIDTH,
   parameter int FRAME_WIDTH    = hub75_pkg::FRAME_WIDTH,
   parameter int UNDERRUN_WIDTH = 16
) (
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic                      i_enable,
   output logic                      o_gen_start,
   output logic [Y_WIDTH-1:0]        o_gen_y,
   output logic [FRAME_WIDTH-1:0]    o_gen_frame_count,
   input  logic                      i_gen_is_idle,
   output logic                      o_disp_start,
   output logic [Y_WIDTH-1:0]        o_disp_y,
   input  logic                      i_disp_done,
   output logic                      o_frame_tick,
   output logic [1:0]                o_bank_valid,
   output logic [UNDERRUN_WIDTH-1:0] o_underrun_count
);

   import hub75_pkg::*;

   fill_state_t               r_fill_state, w_fill_next;
   disp_state_t               r_disp_state, w_disp_next;
   logic [1:0]                r_bank_valid;
   logic                      r_disp_start;
   logic                      r_frame_tick;
   logic [UNDERRUN_WIDTH-1:0] r_underrun;

   logic [Y_WIDTH-1:0]        w_fill_y, w_disp_y;
   logic                      w_fill_done, w_fill_wrap;
   logic                      w_disp_go, w_disp_done, w_stall;
   logic [1:0]                w_bank_set, w_bank_clr;
   logic                      w_disp_wrap_unused, w_frame_carry_unused;

   row_pointer #(.ROWS(ROWS), .Y_WIDTH(Y_WIDTH)) u_fill_ptr (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_inc(w_fill_done),
      .o_y(w_fill_y), .o_wrap(w_fill_wrap)
   );

   row_pointer #(.ROWS(ROWS), .Y_WIDTH(Y_WIDTH)) u_disp_ptr (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_inc(w_disp_done),
      .o_y(w_disp_y), .o_wrap(w_disp_wrap_unused)
   );

   CascadeCounter #(.WIDTH(FRAME_WIDTH)) u_frame_cnt (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_carry_in(w_fill_wrap),
      .o_count(o_gen_frame_count), .o_carry_out(w_frame_carry_unused)
   );

   // Fill sequencing: start only into a free bank with an idle generator; kArm hides the generator's wake-up cycle.
   always_comb begin
      w_fill_next = r_fill_state;
      w_fill_done = 1'b0;
      case (r_fill_state)
         kIdle: if (i_enable && !r_bank_valid[w_fill_y[0]] && i_gen_is_idle) w_fill_next = kArm;
         kArm:  w_fill_next = kBusy;
         kBusy: if (i_gen_is_idle) begin
            w_fill_next = kIdle;
            w_fill_done = 1'b1;
         end
         default: w_fill_next = kIdle;
      endcase
   end

   // Display sequencing: a stall is charged once, on entry to the wait state, if the bank is not ready yet.
   always_comb begin
      w_disp_next = r_disp_state;
      w_disp_go   = 1'b0;
      w_disp_done = 1'b0;
      w_stall     = 1'b0;
      case (r_disp_state)
         kDispIdle: if (i_enable || (|r_bank_valid)) begin
            w_disp_next = kDispWait;
            w_stall     = i_enable && !r_bank_valid[w_disp_y[0]];
         end
         kDispWait: if (r_bank_valid[w_disp_y[0]]) begin
            w_disp_next = kDispBusy;
            w_disp_go   = 1'b1;
         end
         kDispBusy: if (i_disp_done) begin
            w_disp_next = kDispIdle;
            w_disp_done = 1'b1;
         end
         default: w_disp_next = kDispIdle;
      endcase
   end

   // Fill sets only a free bank and display clears only a full one, so both can land in the same edge.
   assign w_bank_set = {w_fill_done & w_fill_y[0], w_fill_done & ~w_fill_y[0]};
   assign w_bank_clr = {w_disp_done & w_disp_y[0], w_disp_done & ~w_disp_y[0]};

   // State, bank flags, registered strobes and the saturating stall counter.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_fill_state <= kIdle;
         r_disp_state <= kDispIdle;
         r_bank_valid <= 2'b00;
         r_disp_start <= 1'b0;
         r_frame_tick <= 1'b0;
         r_underrun   <= '0;
      end else begin
         r_fill_state <= w_fill_next;
         r_disp_state <= w_disp_next;
         r_bank_valid <= (r_bank_valid | w_bank_set) & ~w_bank_clr;
         r_disp_start <= w_disp_go;
         r_frame_tick <= w_fill_wrap;
         if (w_stall && (r_underrun != '1)) r_underrun <= r_underrun + 1'b1;
      end
   end

   assign o_gen_start      = (r_fill_state == kArm);
   assign o_gen_y          = w_fill_y;
   assign o_disp_start     = r_disp_start;
   assign o_disp_y         = w_disp_y;
   assign o_frame_tick     = r_frame_tick;
   assign o_bank_valid     = r_bank_valid;
   assign o_underrun_count = r_underrun;

endmodule

// File: tb/tb_line_scheduler.sv
// Bench for line_scheduler: generator and scan-out responders, a row/bank reference model, directed and random phases.
// Latency: outputs are compared on every falling edge against the model.
// Backpressure: scan-out latency is programmable, including never finishing.
module tb_line_scheduler;

   localparam int ROWS = 8;
   localparam int YW   = 3;
   localparam int FW   = 3;
   localparam int UW   = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          en    = 1'b0;
   logic          gidle = 1'b1;
   logic          ddone = 1'b0;
   logic          o_gen_start, o_disp_start, o_frame_tick;
   logic [YW-1:0] o_gen_y, o_disp_y;
   logic [FW-1:0] o_gen_frame_count;
   logic [1:0]    o_bank_valid;
   logic [UW-1:0] o_underrun_count;

   always #5 clk = ~clk;

   line_scheduler #(.ROWS(ROWS), .Y_WIDTH(YW), .FRAME_WIDTH(FW), .UNDERRUN_WIDTH(UW)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_enable(en),
      .o_gen_start(o_gen_start), .o_gen_y(o_gen_y), .o_gen_frame_count(o_gen_frame_count),
      .i_gen_is_idle(gidle), .o_disp_start(o_disp_start), .o_disp_y(o_disp_y),
      .i_disp_done(ddone), .o_frame_tick(o_frame_tick), .o_bank_valid(o_bank_valid),
      .o_underrun_count(o_underrun_count)
   );

   int n_vec = 0, n_bad = 0, cyc = 0;
   int gen_lo = 4, gen_hi = 4, gen_cnt = 0;
   int disp_lat = 1, disp_cnt = 0;
   int gs_cnt = 0, tick_cnt = 0;

   // Reference model: which rows are rendered/shown, which banks hold a finished line, what happens next.
   int       m_fill_row, m_disp_row, m_frame, m_stall;
   int       m_filling;   // 0: waiting for a chance, 1: start pulse out, 2: generator rendering
   int       m_showing;   // 0: nothing requested, 1: waiting for line, 2: line on the panel
   bit [1:0] m_ready;
   bit       m_gs, m_ds, m_ft;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_fill_row = 0; m_disp_row = 0; m_frame = 0; m_stall = 0;
      m_filling = 0; m_showing = 0; m_ready = 2'b00;
      m_gs = 0; m_ds = 0; m_ft = 0;
   endtask

   task automatic model_step();
      bit [1:0] was = m_ready;
      bit [1:0] filled = 2'b00, shown = 2'b00;
      int fb = m_fill_row % 2;
      int db = m_disp_row % 2;
      m_gs = 0; m_ds = 0; m_ft = 0;
      if (m_filling == 0) begin
         if (en && !was[fb] && gidle) begin m_filling = 1; m_gs = 1; end
      end else if (m_filling == 1) begin
         m_filling = 2;
      end else if (gidle) begin
         m_filling = 0;
         filled[fb] = 1'b1;
         if (m_fill_row == ROWS - 1) begin m_ft = 1; m_frame = (m_frame + 1) % (1 << FW); end
         m_fill_row = (m_fill_row + 1) % ROWS;
      end
      if (m_showing == 0) begin
         if (en || was != 2'b00) begin
            m_showing = 1;
            if (en && !was[db] && m_stall < (1 << UW) - 1) m_stall++;
         end
      end else if (m_showing == 1) begin
         if (was[db]) begin m_showing = 2; m_ds = 1; end
      end else if (ddone) begin
         m_showing = 0;
         shown[db] = 1'b1;
         m_disp_row = (m_disp_row + 1) % ROWS;
      end
      m_ready = (was | filled) & ~shown;
   endtask

   function automatic logic [17:0] dut_pack();
      return {o_gen_start, o_gen_y, o_gen_frame_count, o_disp_start, o_disp_y,
              o_frame_tick, o_bank_valid, o_underrun_count};
   endfunction

   function automatic logic [17:0] model_pack();
      return {m_gs, YW'(m_fill_row), FW'(m_frame), m_ds, YW'(m_disp_row),
              m_ft, m_ready, UW'(m_stall)};
   endfunction

   // One clock: advance the model at the rising edge, compare and respond at the falling edge.
   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      @(negedge clk);
      cyc++;
      check("outputs", 64'(dut_pack()), 64'(model_pack()));
      if (o_gen_start) gs_cnt++;
      if (o_frame_tick) tick_cnt++;
      if (!rst_n) begin
         gen_cnt = 0; gidle = 1'b1;
      end else if (o_gen_start) begin
         gen_cnt = int'($urandom_range(gen_hi, gen_lo)); gidle = 1'b0;
      end else if (gen_cnt > 0) begin
         gen_cnt--; gidle = (gen_cnt == 0);
      end
      ddone = 1'b0;
      if (!rst_n) begin
         disp_cnt = 0;
      end else if (o_disp_start) begin
         disp_cnt = disp_lat;
      end else if (disp_cnt > 0) begin
         disp_cnt--;
         if (disp_cnt == 0) ddone = 1'b1;
      end
   endtask

   task automatic do_reset();
      en = 1'b0; rst_n = 1'b0;
      gen_cnt = 0; gidle = 1'b1; disp_cnt = 0; ddone = 1'b0;
      step(); step();
      check("reset_state", 64'(dut_pack()), 64'd0);
      rst_n = 1'b1; gs_cnt = 0; tick_cnt = 0;
   endtask

   task automatic run_until_tick(input string name, input int bound);
      int k = 0;
      do begin step(); k++; end while (!o_frame_tick && k < bound);
      if (!o_frame_tick) check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   initial begin
      int k;
      #1;
      // First line: 64-cycle generator, quick scan-out.
      do_reset();
      gen_lo = 64; gen_hi = 64; disp_lat = 1; en = 1'b1;
      step();
      check("first_gen_start", 64'(o_gen_start), 64'd1);
      check("first_gen_y", 64'(o_gen_y), 64'd0);
      k = 1;
      while (o_bank_valid == 2'b00 && k < 200) begin step(); k++; end
      check("fill_cycles", 64'(k), 64'd66);
      check("bank_after_fill", 64'(o_bank_valid), 64'b01);
      step();
      check("disp_start", 64'(o_disp_start), 64'd1);
      check("disp_start_y", 64'(o_disp_y), 64'd0);

      // Scan-out never finishes: both banks fill, then the fill side parks.
      do_reset();
      gen_lo = 5; gen_hi = 20; disp_lat = 0; en = 1'b1;
      repeat (300) step();
      check("stuck_gen_starts", 64'(gs_cnt), 64'd2);
      check("stuck_banks", 64'(o_bank_valid), 64'b11);
      check("stuck_fill_y", 64'(o_gen_y), 64'd2);

      // Full frame, then run the frame counter around.
      do_reset();
      gen_lo = 3; gen_hi = 10; disp_lat = 1; en = 1'b1;
      run_until_tick("frame1", 2000);
      check("frame1_fills", 64'(gs_cnt), 64'(ROWS));
      check("frame1_ticks", 64'(tick_cnt), 64'd1);
      check("frame1_count", 64'(o_gen_frame_count), 64'd1);
      check("frame1_fill_y", 64'(o_gen_y), 64'd0);
      for (int f = 0; f < 6; f++) run_until_tick("frames", 2000);
      check("frame_max", 64'(o_gen_frame_count), 64'((1 << FW) - 1));
      run_until_tick("frame_wrap", 2000);
      check("frame_wrap_count", 64'(o_gen_frame_count), 64'd0);
      check("frame_wrap_tick", 64'(o_frame_tick), 64'd1);

      // Slow generator: one stall per row, then saturation.
      do_reset();
      gen_lo = 200; gen_hi = 200; disp_lat = 1; en = 1'b1;
      run_until_tick("slow1", 3000);
      check("underrun_frame1", 64'(o_underrun_count), 64'(ROWS));
      run_until_tick("slow2", 3000);
      check("underrun_saturated", 64'(o_underrun_count), 64'((1 << UW) - 1));

      // Reset while rendering row 5, then enable drop mid-fill.
      do_reset();
      gen_lo = 3; gen_hi = 10; disp_lat = 1; en = 1'b1;
      k = 0;
      do begin step(); k++; end while (!(o_gen_start && o_gen_y == 3'd5) && k < 1000);
      check("row5_reached", 64'(o_gen_y), 64'd5);
      step(); step();
      #2 rst_n = 1'b0;
      #1 check("async_reset", 64'(dut_pack()), 64'd0);
      model_reset();
      gen_cnt = 0; gidle = 1'b1; disp_cnt = 0; ddone = 1'b0;
      step();
      rst_n = 1'b1;
      k = 0;
      do begin step(); k++; end while (!o_gen_start && k < 20);
      check("restart_gen_start", 64'(o_gen_start), 64'd1);
      check("restart_gen_y", 64'(o_gen_y), 64'd0);
      step(); step();
      en = 1'b0; gs_cnt = 0;
      repeat (100) step();
      check("disabled_gen_starts", 64'(gs_cnt), 64'd0);
      check("disabled_fill_y", 64'(o_gen_y), 64'd1);
      check("disabled_drained", 64'(o_bank_valid), 64'b00);

      // Random enable, generator and scan-out timing.
      do_reset();
      for (int b = 0; b < 30; b++) begin
         en       = ($urandom_range(3, 0) != 0);
         gen_lo   = int'($urandom_range(8, 1));
         gen_hi   = gen_lo + int'($urandom_range(20, 0));
         disp_lat = int'($urandom_range(12, 1));
         repeat (20) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
